// File: rtl/hw_backdoor_loader.sv
// hw_backdoor_loader
// Turns a framed byte stream into single-cycle backdoor write strobes
// (address / 32-bit data / 64-bit data / enable). These strobes preload
// instruction and data memory before the core leaves reset.
// Frame layout: header | 8-byte LE address | N LE data words | [checksum].
// Header 0x01 selects 32-bit words and 0x02 selects 64-bit words.
// Optional feature macro: HW_LOADER_CHKSUM_EN. When it is defined, each
// frame ends with one byte holding the 8-bit sum of all earlier frame bytes.

module hw_backdoor_loader #(
  parameter int          CNT_W    = 16,
  parameter logic [63:0] ADDR_RST = 64'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic [63:0]      hw_address,
  output logic [31:0]      hw_data,
  output logic [63:0]      hw_data64,
  output logic             hw_enable,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] frame_words
);

  typedef enum logic [2:0] {
    st_idle,
    st_addr,
    st_data,
    st_emit,
    st_drain
`ifdef HW_LOADER_CHKSUM_EN
    , st_csum
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        ready_q;
  logic [2:0]  cnt_q;
  logic        wide_q;
  logic        last_q;
  logic [63:0] addr_q;
  logic [63:0] word_q;

  logic        accept;
  logic        hdr_ok;
  logic        aligned;
  logic        word_done;
  logic [2:0]  last_idx;
  logic [63:0] addr_nxt;
  logic [63:0] word_nxt;
  logic [63:0] addr_step;

`ifdef HW_LOADER_CHKSUM_EN
  logic [7:0]  csum_q;
  logic [7:0]  chk_q;
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_ok    = (in_data == 8'h01) || (in_data == 8'h02);
  assign last_idx  = wide_q ? 3'd7 : 3'd3;
  assign word_done = (cnt_q == last_idx);
  assign addr_nxt  = {in_data, addr_q[63:8]};
  assign aligned   = wide_q ? (addr_nxt[2:0] == 3'b000) : (addr_nxt[1:0] == 2'b00);
  assign addr_step = wide_q ? 64'd8 : 64'd4;
  assign busy      = (state_q != st_idle);

  // Hold in_ready low through reset and raise it on the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // Accept bytes in every state except the single-cycle emit and checksum states.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      st_idle, st_addr, st_data, st_drain: in_ready = ready_q;
      default:                             in_ready = 1'b0;
    endcase
  end

  // Merge the incoming byte into its little-endian lane of the word being built.
  always_comb begin
    word_nxt = word_q;
    word_nxt[{cnt_q, 3'b000} +: 8] = in_data;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= st_idle;
    else        state_q <= state_d;
  end

  // Next-state logic. Any early in_last drops the frame back to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle: begin
        if (accept && !in_last) state_d = hdr_ok ? st_addr : st_drain;
      end
      st_addr: begin
        if (accept) begin
          if (in_last)                 state_d = st_idle;
          else if (cnt_q == 3'd7)      state_d = aligned ? st_data : st_drain;
        end
      end
      st_data: begin
        if (accept) begin
          if (word_done) begin
            state_d = st_emit;
          end else if (in_last) begin
`ifdef HW_LOADER_CHKSUM_EN
            state_d = (cnt_q == 3'd0) ? st_csum : st_idle;
`else
            state_d = st_idle;
`endif
          end
        end
      end
      st_emit:  state_d = last_q ? st_idle : st_data;
      st_drain: begin
        if (accept && in_last) state_d = st_idle;
      end
`ifdef HW_LOADER_CHKSUM_EN
      st_csum:  state_d = st_idle;
`endif
      default:  state_d = st_idle;
    endcase
  end

  // Datapath: header decode, address and word assembly, strobe generation, error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 3'd0;
      wide_q      <= 1'b0;
      last_q      <= 1'b0;
      addr_q      <= 64'h0;
      word_q      <= 64'h0;
      hw_address  <= ADDR_RST;
      hw_data     <= 32'h0;
      hw_data64   <= 64'h0;
      hw_enable   <= 1'b0;
      error       <= 1'b0;
      frame_words <= '0;
    end else begin
      hw_enable <= 1'b0;
      case (state_q)
        st_idle: begin
          if (accept) begin
            if (hdr_ok) begin
              error       <= 1'b0;
              frame_words <= '0;
              wide_q      <= (in_data == 8'h02);
              cnt_q       <= 3'd0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        st_addr: begin
          if (accept) begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q + 3'd1;
            if (in_last || ((cnt_q == 3'd7) && !aligned)) error <= 1'b1;
          end
        end
        st_data: begin
          if (accept) begin
            word_q <= word_nxt;
            if (word_done) begin
              cnt_q      <= 3'd0;
              last_q     <= in_last;
              hw_enable  <= 1'b1;
              hw_address <= addr_q;
              hw_data    <= word_nxt[31:0];
              hw_data64  <= wide_q ? word_nxt : {32'h0, word_nxt[31:0]};
`ifdef HW_LOADER_CHKSUM_EN
              if (in_last) error <= 1'b1;
`endif
            end else if (in_last) begin
              cnt_q <= 3'd0;
`ifdef HW_LOADER_CHKSUM_EN
              if (cnt_q != 3'd0) error <= 1'b1;
`else
              error <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        st_emit: begin
          addr_q <= addr_q + addr_step;
          if (frame_words != {CNT_W{1'b1}}) frame_words <= frame_words + CNT_W'(1);
        end
`ifdef HW_LOADER_CHKSUM_EN
        st_csum: begin
          if (chk_q != csum_q) error <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef HW_LOADER_CHKSUM_EN
  // Running 8-bit sum of frame bytes; the trailing checksum byte is captured separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 8'h00;
      chk_q  <= 8'h00;
    end else if (accept) begin
      if (state_q == st_idle)
        csum_q <= in_data;
      else if ((state_q == st_data) && in_last && (cnt_q == 3'd0))
        chk_q <= in_data;
      else
        csum_q <= csum_q + in_data;
    end
  end
`endif

endmodule

// File: tb/tb_hw_backdoor_loader.sv
// Testbench for hw_backdoor_loader: directed frames plus randomized frames
// checked against a frame-level reference model. Honors HW_LOADER_CHKSUM_EN.

module tb_hw_backdoor_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic [63:0] hw_address;
  logic [31:0] hw_data;
  logic [63:0] hw_data64;
  logic        hw_enable;
  logic        busy;
  logic        error;
  logic [15:0] frame_words;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  bit drop_last = 1'b0;

  logic [7:0]  frame_q[$];
  logic [63:0] exp_addr[$];
  logic [63:0] exp_d32[$];
  logic [63:0] exp_d64[$];
  logic [63:0] obs_addr[$];
  logic [63:0] obs_d32[$];
  logic [63:0] obs_d64[$];
  int          obs_cyc[$];
  bit          m_err = 1'b0;
  int          m_fw = 0;
  bit          m_last_word = 1'b0;

  hw_backdoor_loader #(.CNT_W(16), .ADDR_RST(64'h0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .hw_address(hw_address),
    .hw_data(hw_data), .hw_data64(hw_data64), .hw_enable(hw_enable),
    .busy(busy), .error(error), .frame_words(frame_words)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe seen on the backdoor bus.
  always @(negedge clk) begin
    if (rst_n && hw_enable) begin
      obs_addr.push_back(hw_address);
      obs_d32.push_back({32'h0, hw_data});
      obs_d64.push_back(hw_data64);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference model: derives the expected strobes, error flag and word count of a whole frame.
  task automatic model_frame();
    int n, w, p, words, rem;
    logic [63:0] a, word;
    logic [7:0]  s;
    n = frame_q.size();
    exp_addr.delete(); exp_d32.delete(); exp_d64.delete();
    m_last_word = 1'b0;
    if (frame_q[0] != 8'h01 && frame_q[0] != 8'h02) begin
      m_err = 1'b1;
      return;
    end
    m_err = 1'b0;
    m_fw  = 0;
    if (n == 1) return;
    w = (frame_q[0] == 8'h01) ? 4 : 8;
    if (n <= 9) begin
      m_err = 1'b1;
      return;
    end
    a = 64'h0;
    for (int k = 0; k < 8; k++) a[8*k +: 8] = frame_q[1+k];
    if ((a % 64'(w)) != 64'd0) begin
      m_err = 1'b1;
      return;
    end
    p = n - 9;
    words = p / w;
    rem = p % w;
`ifdef HW_LOADER_CHKSUM_EN
    if (rem == 1) begin
      s = 8'h00;
      for (int k = 0; k < n - 1; k++) s = s + frame_q[k];
      if (s != frame_q[n-1]) m_err = 1'b1;
    end else begin
      m_err = 1'b1;
      m_last_word = (rem == 0);
    end
`else
    if (rem != 0) m_err = 1'b1;
    else          m_last_word = 1'b1;
`endif
    for (int i = 0; i < words; i++) begin
      word = 64'h0;
      for (int k = 0; k < w; k++) word[8*k +: 8] = frame_q[9 + i*w + k];
      exp_addr.push_back(a + 64'(i*w));
      exp_d32.push_back({32'h0, word[31:0]});
      exp_d64.push_back(word);
    end
    m_fw = words;
  endtask

  // Drive the queued frame with random valid gaps, obeying in_ready.
  task automatic applyStimulus();
    int i = 0;
    int guard = 0;
    while (i < frame_q.size() && guard < 5000) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = frame_q[i];
        in_last  = !drop_last && (i == frame_q.size() - 1);
      end
      if (in_valid && in_ready) begin
        if (i == frame_q.size() - 1) last_acc_cyc = cyc;
        i++;
      end
    end
    if (i < frame_q.size()) checkOutput("send_timeout", 64'(i), 64'(frame_q.size()));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("busy_end", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_d32.delete(); obs_d64.delete(); obs_cyc.delete();
  endtask

  task automatic run_frame(input string tag);
    int ns;
    model_frame();
    applyStimulus();
    wait_idle();
    checkOutput({tag, "_nstrobe"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    ns = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < ns; i++) begin
      checkOutput({tag, "_addr"}, obs_addr[i], exp_addr[i]);
      checkOutput({tag, "_d32"},  obs_d32[i],  exp_d32[i]);
      checkOutput({tag, "_d64"},  obs_d64[i],  exp_d64[i]);
    end
    if (m_last_word && obs_cyc.size() > 0)
      checkOutput({tag, "_latency"}, 64'(obs_cyc[obs_cyc.size()-1]), 64'(last_acc_cyc + 1));
    checkOutput({tag, "_error"}, 64'(error), 64'(m_err));
    checkOutput({tag, "_fwords"}, 64'(frame_words), 64'(m_fw));
    checkOutput({tag, "_enable"}, 64'(hw_enable), 64'd0);
    clear_obs();
  endtask

  task automatic push_addr(input logic [63:0] a);
    for (int k = 0; k < 8; k++) frame_q.push_back(a[8*k +: 8]);
  endtask

  task automatic append_sum(input bit corrupt);
    logic [7:0] s = 8'h00;
    foreach (frame_q[k]) s = s + frame_q[k];
    if (corrupt) s = s ^ 8'h5A;
    frame_q.push_back(s);
  endtask

  task automatic build_test1();
    frame_q.delete();
    frame_q.push_back(8'h01);
    push_addr(64'h8000_0000);
    frame_q.push_back(8'h13); frame_q.push_back(8'h00); frame_q.push_back(8'h00); frame_q.push_back(8'h00);
    frame_q.push_back(8'h93); frame_q.push_back(8'h00); frame_q.push_back(8'h10); frame_q.push_back(8'h00);
  endtask

  task automatic build_random();
    int r, w, nw;
    logic [63:0] a;
    logic [7:0]  b;
    frame_q.delete();
    r = $urandom_range(0, 11);
    if (r == 0) begin
      b = 8'($urandom_range(3, 255));
      frame_q.push_back(b);
      for (int k = 0; k < $urandom_range(0, 5); k++) frame_q.push_back(8'($urandom()));
      return;
    end
    frame_q.push_back((r < 6) ? 8'h01 : 8'h02);
    if (r == 11) return;
    w = (r < 6) ? 4 : 8;
    a = {$urandom(), $urandom()};
    if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
    a = a & ~64'(w - 1);
    if ($urandom_range(0, 7) == 0) a = a | 64'($urandom_range(1, w - 1));
    push_addr(a);
    nw = $urandom_range(0, 3);
    for (int k = 0; k < nw * w; k++) frame_q.push_back(8'($urandom()));
    if (nw > 0 && $urandom_range(0, 7) == 0)
      for (int k = 0; k < $urandom_range(1, w - 1); k++) void'(frame_q.pop_back());
    else if ($urandom_range(0, 7) == 0)
      frame_q.push_back(8'($urandom()));
`ifdef HW_LOADER_CHKSUM_EN
    if ($urandom_range(0, 3) != 0) append_sum($urandom_range(0, 3) == 0);
`endif
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst0_ready", 64'(in_ready), 64'd0);
    checkOutput("rst0_addr", hw_address, 64'h0);
    checkOutput("rst0_d32", 64'(hw_data), 64'h0);
    checkOutput("rst0_d64", hw_data64, 64'h0);
    checkOutput("rst0_en", 64'(hw_enable), 64'd0);
    checkOutput("rst0_busy", 64'(busy), 64'd0);
    checkOutput("rst0_err", 64'(error), 64'd0);
    checkOutput("rst0_fw", 64'(frame_words), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("ready_after_rst", 64'(in_ready), 64'd1);

    build_test1();
    run_frame("t1");

    frame_q.delete();
    frame_q.push_back(8'h02);
    push_addr(64'h1000);
    frame_q.push_back(8'h88); frame_q.push_back(8'h77); frame_q.push_back(8'h66); frame_q.push_back(8'h55);
    frame_q.push_back(8'h44); frame_q.push_back(8'h33); frame_q.push_back(8'h22); frame_q.push_back(8'h11);
    run_frame("t2");

    frame_q.delete();
    frame_q.push_back(8'h02);
    push_addr(64'hFFFF_FFFF_FFFF_FFF8);
    for (int k = 0; k < 16; k++) frame_q.push_back(8'($urandom()));
    run_frame("t3");

    frame_q.delete();
    frame_q.push_back(8'h07);
    for (int k = 0; k < 5; k++) frame_q.push_back(8'($urandom()));
    run_frame("t4_bad");
    frame_q.delete();
    frame_q.push_back(8'h01);
    run_frame("t4_clear");

    frame_q.delete();
    frame_q.push_back(8'h01);
    push_addr(64'h2);
    frame_q.push_back(8'h11); frame_q.push_back(8'h22); frame_q.push_back(8'h33); frame_q.push_back(8'h44);
    run_frame("t5_misalign");

    frame_q.delete();
    frame_q.push_back(8'h01);
    push_addr(64'h100);
    frame_q.push_back(8'hAA); frame_q.push_back(8'hBB);
    run_frame("t5_midlast");

    frame_q.delete();
    frame_q.push_back(8'h01);
    push_addr(64'h200);
    frame_q.push_back(8'h11); frame_q.push_back(8'h22);
    drop_last = 1'b1;
    applyStimulus();
    drop_last = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst1_ready", 64'(in_ready), 64'd0);
    checkOutput("rst1_addr", hw_address, 64'h0);
    checkOutput("rst1_d32", 64'(hw_data), 64'h0);
    checkOutput("rst1_d64", hw_data64, 64'h0);
    checkOutput("rst1_en", 64'(hw_enable), 64'd0);
    checkOutput("rst1_busy", 64'(busy), 64'd0);
    checkOutput("rst1_err", 64'(error), 64'd0);
    checkOutput("rst1_fw", 64'(frame_words), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst1_nstrobe", 64'(obs_addr.size()), 64'd0);
    clear_obs();
    m_err = 1'b0;
    m_fw  = 0;

`ifdef HW_LOADER_CHKSUM_EN
    build_test1();
    append_sum(1'b0);
    run_frame("t6_good");
    build_test1();
    append_sum(1'b1);
    run_frame("t6_bad");
`endif

    for (int f = 0; f < 40; f++) begin
      build_random();
      run_frame($sformatf("rnd%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
